demux1to2_pkt: RTL and testbench
================================

DEMUX1TO2_PKT -- requirements
Module: demux1to2_pkt

Interface
REQ-001 Parameter: WIDTH, 8, payload width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_data  input  WIDTH  payload beat.
REQ-005 Port: in_last  input  1  final beat of packet.
REQ-006 Port: in_valid  input  1  beat offered.
REQ-007 Port: in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 Port: sel  input  1  destination for a packet's first beat: 1 -> port A, 0 -> port B.
REQ-009 Port: a_data, b_data  output  WIDTH each  registered payload.
REQ-010 Port: a_last, b_last  output  1 each  registered last flag.
REQ-011 Port: a_valid, b_valid  output  1 each  output beat present.
REQ-012 Port: a_ready, b_ready  input  1 each  downstream accepts.
REQ-013 Port (only with DEMUX_CNT_EN): a_pkt_cnt, b_pkt_cnt  output  8 each  delivered-packet counts.

Function
REQ-014 Each output has one register slot; accepted beat appears on the selected output the cycle after acceptance (latency 1).
REQ-015 dst = sel in ST_IDLE; dst = A in ST_LOCKA; dst = B in ST_LOCKB.
REQ-016 in_ready = !dst_valid || dst_ready (combinational; no dependence on in_valid).
REQ-017 On acceptance: dst slot loads in_data and in_last; dst_valid set next cycle.
REQ-018 A slot with valid && ready and no new load clears valid next cycle; with a simultaneous load it stays valid with the new beat.
REQ-019 While valid && !ready, slot data, last and valid are held stable.
REQ-020 The non-destination slot drains independently in the same cycle; at most one slot loads per cycle.
REQ-021 FSM: ST_IDLE -> ST_LOCKA/ST_LOCKB on accepted beat with in_last=0 (per sel); ST_LOCKx -> ST_IDLE on accepted beat with in_last=1; otherwise hold.
REQ-022 Single-beat packet (in_last=1 in ST_IDLE): routed per sel, state stays ST_IDLE.
REQ-023 sel is ignored in ST_LOCKA/ST_LOCKB; a packet never splits across outputs.
REQ-024 No beat is dropped or duplicated; beat order per output equals input order.

Reset
REQ-025 rst_n low: state ST_IDLE; a_valid, b_valid, a_last, b_last = 0; a_data, b_data = 0; counters = 0, immediately and asynchronously.
REQ-026 Reset mid-packet discards slot contents and lock; first accepted beat after release is treated as a packet start.
REQ-027 Release takes effect at the first clk edge after rst_n rises.

Configuration
REQ-028 Macro DEMUX_CNT_EN defined: a_pkt_cnt/b_pkt_cnt present; each increments when its slot has valid && ready && last; 8-bit, wraps 255 -> 0.
REQ-029 DEMUX_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 Package demux_pkg holds state typedef (ST_IDLE, ST_LOCKA, ST_LOCKB), default WIDTH constant and CNT_W = 8.
REQ-031 Sub-module out_slot (one-entry register slot with valid/ready, data, last, optional counter) instantiated twice.

Verification
REQ-032 Reset with in_valid=1, in_data=8'h5A -> a_valid=b_valid=0, in_ready=1, counters 0.
REQ-033 sel=1, beats 8'h11,8'h22,8'h33(last), a_ready=1, sel toggled mid-packet -> a_data 11,22,33 on consecutive cycles each one cycle after accept, b_valid never 1.
REQ-034 b_ready=0, sel=0, beat 8'h44(last) then 8'h55 -> 44 held on b_data, in_ready=0 for 55 until b_ready=1, then 55 follows next cycle.
REQ-035 a slot full with a_ready=0, sel=0 single beat 8'h66 -> accepted and delivered on B while A stays stalled.
REQ-036 rst_n pulsed low after first beat of 3-beat A packet -> outputs cleared; next beat with sel=0 goes to B.
REQ-037 DEMUX_CNT_EN, 257 single-beat packets to A -> a_pkt_cnt = 1, b_pkt_cnt = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 packet demultiplexer.
// The optional per-port delivered-packet counters are enabled by defining DEMUX_CNT_EN.
package demux_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCKA = 2'd1,
        ST_LOCKB = 2'd2
    } state_t;

    // A multi-beat packet locks its destination until the beat carrying last is accepted.
    function automatic state_t next_state(input state_t cur, input logic accept,
                                          input logic last, input logic to_a);
        state_t nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (accept && !last) begin
                    nxt = to_a ? ST_LOCKA : ST_LOCKB;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_LOCKA, ST_LOCKB: begin
                if (accept && last) begin
                    nxt = ST_IDLE;
                end else begin
                    nxt = cur;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register slot with valid/ready handshake.
// With DEMUX_CNT_EN defined it also counts delivered packets (wrapping).
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             can_load,
`ifdef DEMUX_CNT_EN
    output logic [CNT_W-1:0] pkt_cnt,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_r;
    logic             last_r;
    logic             valid_r;
    logic             drain_s;

    assign drain_s   = valid_r && out_ready;
    assign can_load  = !valid_r || out_ready;
    assign out_data  = data_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;

    // Slot storage: a load wins over a drain, a stalled beat is held untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {WIDTH{1'b0}};
            last_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            last_r  <= load_last;
            valid_r <= 1'b1;
        end else if (drain_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_r;
    assign pkt_cnt = cnt_r;

    // Delivered-packet counter, bumped when a last beat leaves the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (drain_s && last_r) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

endmodule

// File: rtl/demux1to2_pkt.sv
// Packet-aware 1-to-2 demultiplexer: the first beat's sel picks the port for the whole packet.
// Define DEMUX_CNT_EN to add a_pkt_cnt/b_pkt_cnt delivered-packet counters.
module demux1to2_pkt
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             b_valid,
`ifdef DEMUX_CNT_EN
    output logic [CNT_W-1:0] a_pkt_cnt,
    output logic [CNT_W-1:0] b_pkt_cnt,
`endif
    input  logic             b_ready
);

    state_t state_r;
    logic   dst_a_s;
    logic   a_can_s;
    logic   b_can_s;
    logic   accept_s;

    // sel only matters between packets; a locked state pins the destination.
    assign dst_a_s  = (state_r == ST_IDLE) ? sel : (state_r == ST_LOCKA);
    assign in_ready = dst_a_s ? a_can_s : b_can_s;
    assign accept_s = in_valid && in_ready;

    // Packet lock state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state(state_r, accept_s, in_last, dst_a_s);
        end
    end

    out_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_s && dst_a_s),
        .load_data (in_data),
        .load_last (in_last),
        .can_load  (a_can_s),
`ifdef DEMUX_CNT_EN
        .pkt_cnt   (a_pkt_cnt),
`endif
        .out_data  (a_data),
        .out_last  (a_last),
        .out_valid (a_valid),
        .out_ready (a_ready)
    );

    out_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_s && !dst_a_s),
        .load_data (in_data),
        .load_last (in_last),
        .can_load  (b_can_s),
`ifdef DEMUX_CNT_EN
        .pkt_cnt   (b_pkt_cnt),
`endif
        .out_data  (b_data),
        .out_last  (b_last),
        .out_valid (b_valid),
        .out_ready (b_ready)
    );

endmodule

// File: tb/tb_demux1to2_pkt.sv
// Directed self-checking bench for demux1to2_pkt (counter checks only with DEMUX_CNT_EN).
module tb_demux1to2_pkt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic [7:0] a_data, b_data;
    logic       a_last, b_last;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
`ifdef DEMUX_CNT_EN
    logic [7:0] a_pkt_cnt, b_pkt_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    demux1to2_pkt #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .a_data   (a_data),
        .a_last   (a_last),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_last   (b_last),
        .b_valid  (b_valid),
`ifdef DEMUX_CNT_EN
        .a_pkt_cnt(a_pkt_cnt),
        .b_pkt_cnt(b_pkt_cnt),
`endif
        .b_ready  (b_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
        in_valid = v;
        sel      = s;
        in_data  = d;
        in_last  = l;
        #1;
    endtask

    initial begin
        // Reset asserted with a beat offered
        rst_n = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        drive(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_a_data", {24'd0, a_data}, 32'd0);
        step(); step();
        chk("rst_hold_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_hold_b_last", {31'd0, b_last}, 32'd0);
`ifdef DEMUX_CNT_EN
        chk("rst_a_cnt", {24'd0, a_pkt_cnt}, 32'd0);
        chk("rst_b_cnt", {24'd0, b_pkt_cnt}, 32'd0);
`endif
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        rst_n = 1'b1;

        // 3-beat packet to A, sel toggled mid-packet
        drive(1'b1, 1'b1, 8'h11, 1'b0);
        step();
        chk("a_beat1", {23'd0, a_valid, a_data}, {23'd0, 1'b1, 8'h11});
        drive(1'b1, 1'b0, 8'h22, 1'b0);
        chk("a_lock_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("a_beat2", {23'd0, a_valid, a_data}, {23'd0, 1'b1, 8'h22});
        chk("a_beat2_bv", {31'd0, b_valid}, 32'd0);
        drive(1'b1, 1'b1, 8'h33, 1'b1);
        step();
        chk("a_beat3", {22'd0, a_valid, a_last, a_data}, {22'd0, 1'b1, 1'b1, 8'h33});
        chk("a_beat3_bv", {31'd0, b_valid}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("a_drained", {30'd0, a_valid, b_valid}, 32'd0);

        // B stalled: 44 held, 55 back-pressured until b_ready
        b_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h44, 1'b1);
        chk("b_empty_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("b_44", {22'd0, b_valid, b_last, b_data}, {22'd0, 1'b1, 1'b1, 8'h44});
        drive(1'b1, 1'b0, 8'h55, 1'b1);
        chk("b_full_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("b_44_held", {23'd0, b_valid, b_data}, {23'd0, 1'b1, 8'h44});
        chk("b_full_ready2", {31'd0, in_ready}, 32'd0);
        b_ready = 1'b1;
        #1;
        chk("b_drain_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("b_55", {23'd0, b_valid, b_data}, {23'd0, 1'b1, 8'h55});
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("b_drained", {31'd0, b_valid}, 32'd0);

        // A stalled full, single beat to B still flows
        a_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        step();
        chk("a_77", {23'd0, a_valid, a_data}, {23'd0, 1'b1, 8'h77});
        drive(1'b1, 1'b0, 8'h66, 1'b1);
        chk("b_path_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("b_66", {23'd0, b_valid, b_data}, {23'd0, 1'b1, 8'h66});
        chk("a_77_stalled", {23'd0, a_valid, a_data}, {23'd0, 1'b1, 8'h77});
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        chk("a_full_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("b_66_gone", {31'd0, b_valid}, 32'd0);
        a_ready = 1'b1;
        step();
        chk("a_77_gone", {31'd0, a_valid}, 32'd0);

        // Reset mid-packet discards lock and slot
        a_ready = 1'b0;
        drive(1'b1, 1'b1, 8'hA1, 1'b0);
        step();
        chk("mid_a1", {23'd0, a_valid, a_data}, {23'd0, 1'b1, 8'hA1});
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a", {23'd0, a_valid, a_data}, 32'd0);
        chk("mid_rst_b", {31'd0, b_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hA2, 1'b0);
        step();
        chk("post_rst_b", {23'd0, b_valid, b_data}, {23'd0, 1'b1, 8'hA2});
        chk("post_rst_a", {31'd0, a_valid}, 32'd0);
        b_ready = 1'b1;
        drive(1'b1, 1'b1, 8'hA3, 1'b1);
        step();
        chk("lockb_a3", {22'd0, b_valid, b_last, b_data}, {22'd0, 1'b1, 1'b1, 8'hA3});
        chk("lockb_a_idle", {31'd0, a_valid}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();

`ifdef DEMUX_CNT_EN
        // 257 single-beat packets to A wrap the counter to 1
        rst_n = 1'b0;
        #1;
        chk("cnt_rst_b", {24'd0, b_pkt_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        a_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b1, i[7:0], 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        chk("cnt_a_wrap", {24'd0, a_pkt_cnt}, 32'd1);
        chk("cnt_b_zero", {24'd0, b_pkt_cnt}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
